pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised, handshaked pipeline register: the generic successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB stage structs. It carries an opaque payload of WIDTH bits, typically one packed stage struct, between two pipeline stages. The output side adds valid/ready back-pressure, a synchronous flush for branch/exception squash, an occupancy indicator and a saturating stall counter. One instance sits at each stage boundary of the core.

## Interface
Parameters:
- WIDTH, 32: payload width in bits; must be ≥ 1.
- CNT_W, 16: stall counter width in bits; must be ≥ 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  upstream presents a payload.
- in_ready  out  1  stage can accept; a transfer occurs when in_valid && in_ready.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  stage holds a payload for downstream.
- out_ready  in  1  downstream accepts; a transfer occurs when out_valid && out_ready.
- out_data  out  WIDTH  payload presented downstream.
- flush  in  1  squashes all held entries at the next edge.
- occupancy  out  2  number of held entries: 0–1, or 0–2 with the skid buffer.
- stall_cnt  out  CNT_W  cycles with out_valid && !out_ready; saturating.

## Operation
- Storage:
  - Main entry (main_v, main_d) always drives out_valid and out_data.
  - Skid entry (skid_v, skid_d) exists only with PIPE_SKID_EN.
- Ordering: strict FIFO; no payload is duplicated or reordered.
- States:
  - EMPTY: occupancy 0.
  - ONE: main only.
  - FULL: main and skid; reachable only with PIPE_SKID_EN.
- Transitions, where acc = input transfer and fire = output transfer:
  - EMPTY: acc → ONE, with main_d ← in_data.
  - ONE: acc && fire → ONE, with main_d ← in_data.
  - ONE: acc && !fire → FULL (skid build), with skid_d ← in_data. Without the macro this case cannot occur, because in_ready is forced high only when fire.
  - ONE: !acc && fire → EMPTY.
  - FULL: fire → ONE, with main_d ← skid_d. No acc is possible in FULL.
- Flush:
  - flush = 1 forces EMPTY at the next edge and overrides every transition above.
  - An input transfer in the flush cycle is consumed and discarded.
  - An output transfer in the flush cycle counts as delivered.
- Data registers:
  - Loaded only on the listed transitions.
  - out_data while out_valid = 0 holds the last loaded value and carries no meaning.
- stall_cnt:
  - Increments by 1 each cycle with out_valid && !out_ready.
  - Holds at 2^CNT_W − 1.
  - Cleared only by rst, not by flush.
- occupancy equals main_v + skid_v.

## Timing
- Reset values, one edge after rst = 1:
  - out_valid = 0, occupancy = 0, stall_cnt = 0, out_data = 0.
  - in_ready = 1, both with and without the macro.
  - All entries empty.
- rst has priority over flush and all handshakes. Reset asserted mid-transfer drops every held payload.
- Latency: a payload accepted at edge N is on out_valid/out_data in the cycle after edge N (1 cycle).
- Throughput: one payload per cycle while out_ready = 1.
- in_ready:
  - Without the macro: combinational, !main_v || out_ready.
  - With the macro: registered, !skid_v, with no combinational path from out_ready.
- in_ready must not depend on in_valid.
- out_valid, once asserted, stays high with stable out_data until fire or flush.

## Configuration
- PIPE_SKID_EN defined:
  - 2-entry skid buffer; FULL state exists.
  - in_ready is a flop output, which breaks the ready timing path across the stage.
  - occupancy reaches 2.
- PIPE_SKID_EN undefined:
  - Single entry; the skid registers are not instantiated.
  - in_ready is combinational as above.
  - occupancy ≤ 1.
- Latency and ordering are identical in both builds.

## Test plan
- Reset: hold rst 2 cycles with in_valid = 1 → out_valid = 0, occupancy = 0, stall_cnt = 0, in_ready = 1 after release.
- Streaming: send 0x1, 0x2, 0x3 back-to-back with out_ready = 1 → out_data is 0x1, 0x2, 0x3 on the 3 consecutive cycles following each accept edge; in_ready stays 1.
- Back-pressure: send 0xA then 0xB, and drop out_ready for 4 cycles.
  - With PIPE_SKID_EN: occupancy = 2, in_ready = 0.
  - Without: in_ready = 0 with 0xA held.
  - In both builds stall_cnt = 4; after release, 0xA then 0xB exit in order.
- Flush: with occupancy 2 (skid build), or 1 (otherwise), pulse flush together with in_valid = 1 and in_data = 0xC → next cycle out_valid = 0, occupancy = 0, and 0xC never appears.
- Saturation: with CNT_W = 3, hold out_valid = 1 and out_ready = 0 for 10 cycles → stall_cnt stops at 7; a subsequent flush leaves it at 7.
- Reset mid-stall: assert rst while FULL → all entries cleared; stall_cnt returns to 0 one edge later.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked pipeline register with flush, occupancy and saturating stall counter.
// Define PIPE_SKID_EN to add a second (skid) entry and register in_ready.
module pipe_stage_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    // Encoding equals the number of held entries, so occupancy is a direct decode.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e           state_r;
    logic [WIDTH-1:0] main_d_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic             main_v_s;
    logic             skid_v_s;
    logic             acc_s;
    logic             fire_s;

`ifdef PIPE_SKID_EN
    logic [WIDTH-1:0] skid_d_r;
    logic             in_ready_r;
`endif

    assign main_v_s = (state_r != ST_EMPTY);
    assign skid_v_s = (state_r == ST_FULL);
    assign acc_s    = in_valid && in_ready;
    assign fire_s   = main_v_s && out_ready;

`ifdef PIPE_SKID_EN
    // Ready flop tracks "skid entry free", cutting the out_ready -> in_ready path.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r <= 1'b1;
        end else if (flush) begin
            in_ready_r <= 1'b1;
        end else if ((state_r == ST_ONE) && acc_s && !fire_s) begin
            in_ready_r <= 1'b0;
        end else if ((state_r == ST_FULL) && fire_s) begin
            in_ready_r <= 1'b1;
        end else begin
            in_ready_r <= in_ready_r;
        end
    end

    assign in_ready = in_ready_r;
`else
    assign in_ready = !main_v_s || out_ready;
`endif

    // Entry state machine and payload registers; flush overrides every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_EMPTY;
            main_d_r <= '0;
`ifdef PIPE_SKID_EN
            skid_d_r <= '0;
`endif
        end else if (flush) begin
            state_r <= ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (acc_s) begin
                        state_r  <= ST_ONE;
                        main_d_r <= in_data;
                    end
                end
                ST_ONE: begin
                    if (acc_s && fire_s) begin
                        main_d_r <= in_data;
                    end else if (acc_s) begin
`ifdef PIPE_SKID_EN
                        state_r  <= ST_FULL;
                        skid_d_r <= in_data;
`else
                        // Unreachable: in ONE, in_ready is high only when the output fires.
                        state_r  <= ST_ONE;
`endif
                    end else if (fire_s) begin
                        state_r <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
`ifdef PIPE_SKID_EN
                    if (fire_s) begin
                        state_r  <= ST_ONE;
                        main_d_r <= skid_d_r;
                    end
`else
                    state_r <= ST_EMPTY;
`endif
                end
                default: begin
                    state_r <= ST_EMPTY;
                end
            endcase
        end
    end

    // Saturating stall counter; only reset clears it, flush leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= '0;
        end else if (main_v_s && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign out_valid = main_v_s;
    assign out_data  = main_d_r;
    assign occupancy = {1'b0, main_v_s} + {1'b0, skid_v_s};
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: vector table plus data scoreboard.
// Expectations adapt to the PIPE_SKID_EN build.
module tb_pipe_stage_reg;

`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       flush;
    logic [1:0] occupancy;
    logic [2:0] stall_cnt;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb_q[$];

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       e_ov;
        logic [1:0] e_occ;
        logic       e_ir;
        logic [2:0] e_st;
    } vec_t;

    vec_t vecs[13];

    pipe_stage_reg #(.WIDTH(8), .CNT_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .flush(flush),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic r, input logic iv, input logic [7:0] d,
                          input logic ordy, input logic fl);
        rst       = r;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    // Scoreboard update on the settled handshake, then advance one clock edge.
    task automatic tick();
        logic [7:0] exp_d;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    exp_d = sb_q.pop_front();
                    chk("sb_data", 32'(out_data), 32'(exp_d));
                end
            end
            if (flush) sb_q.delete();
            else if (in_valid && in_ready) sb_q.push_back(in_data);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 8'h01, 1'b1, 1'b0, 2'd0, 1'b1, 3'd0};
        vecs[1]  = '{1'b1, 8'h02, 1'b1, 1'b1, 2'd1, 1'b1, 3'd0};
        vecs[2]  = '{1'b1, 8'h03, 1'b1, 1'b1, 2'd1, 1'b1, 3'd0};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 2'd1, 1'b1, 3'd0};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b1, 3'd0};
        vecs[5]  = '{1'b1, 8'h0A, 1'b1, 1'b0, 2'd0, 1'b1, 3'd0};
        vecs[6]  = '{1'b1, 8'h0B, 1'b0, 1'b1, 2'd1, SKID, 3'd0};
        vecs[7]  = '{!SKID, 8'h0B, 1'b0, 1'b1, SKID ? 2'd2 : 2'd1, 1'b0, 3'd1};
        vecs[8]  = '{!SKID, 8'h0B, 1'b0, 1'b1, SKID ? 2'd2 : 2'd1, 1'b0, 3'd2};
        vecs[9]  = '{!SKID, 8'h0B, 1'b0, 1'b1, SKID ? 2'd2 : 2'd1, 1'b0, 3'd3};
        vecs[10] = '{!SKID, 8'h0B, 1'b1, 1'b1, SKID ? 2'd2 : 2'd1, !SKID, 3'd4};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 2'd1, 1'b1, 3'd4};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b1, 3'd4};

        // Reset held two cycles with in_valid high.
        set_in(1'b1, 1'b1, 8'h55, 1'b0, 1'b0); tick();
        set_in(1'b1, 1'b1, 8'h55, 1'b0, 1'b0); tick();
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);
        tick();

        // Streaming then back-pressure, from the vector table.
        for (int i = 0; i < 13; i++) begin
            set_in(1'b0, vecs[i].iv, vecs[i].d, vecs[i].ordy, 1'b0);
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("vec%0d_occupancy", i), 32'(occupancy), 32'(vecs[i].e_occ));
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
            chk($sformatf("vec%0d_stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].e_st));
            tick();
        end

        // Flush with entries held; 0x0C must never emerge.
        set_in(1'b0, 1'b1, 8'h21, 1'b0, 1'b0); tick();
        set_in(1'b0, SKID, 8'h22, 1'b0, 1'b0); tick();
        set_in(1'b0, 1'b1, 8'h0C, 1'b0, 1'b1);
        chk("flush_pre_occupancy", 32'(occupancy), SKID ? 32'd2 : 32'd1);
        tick();
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_occupancy", 32'(occupancy), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_stall_kept", 32'(stall_cnt), 32'd6);
        tick();
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("flush_still_empty", 32'(out_valid), 32'd0);
        tick();

        // Input transfer in the flush cycle is discarded.
        set_in(1'b0, 1'b1, 8'h0D, 1'b1, 1'b1);
        chk("flush_acc_in_ready", 32'(in_ready), 32'd1);
        tick();
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("flush_acc_dropped", 32'(out_valid), 32'd0);
        chk("flush_acc_occupancy", 32'(occupancy), 32'd0);
        tick();

        // Output transfer in the flush cycle is delivered (scoreboard pops 0x0E).
        set_in(1'b0, 1'b1, 8'h0E, 1'b1, 1'b0); tick();
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("flush_fire_valid", 32'(out_valid), 32'd1);
        tick();
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("flush_fire_after", 32'(out_valid), 32'd0);
        tick();

        // Stall counter saturation at 7, untouched by flush.
        set_in(1'b1, 1'b0, 8'h00, 1'b0, 1'b0); tick();
        set_in(1'b0, 1'b1, 8'h31, 1'b0, 1'b0);
        chk("sat_start", 32'(stall_cnt), 32'd0);
        tick();
        for (int i = 0; i < 10; i++) begin
            set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            if (i == 6) chk("sat_count6", 32'(stall_cnt), 32'd6);
            if (i == 7) chk("sat_count7", 32'(stall_cnt), 32'd7);
            tick();
        end
        set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("sat_held", 32'(stall_cnt), 32'd7);
        chk("sat_data_stable", 32'(out_data), 32'h31);
        tick();
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("sat_after_flush", 32'(stall_cnt), 32'd7);
        chk("sat_flush_valid", 32'(out_valid), 32'd0);
        tick();

        // Reset while holding entries drops them and clears the counter.
        set_in(1'b0, 1'b1, 8'h41, 1'b0, 1'b0); tick();
        set_in(1'b0, SKID, 8'h42, 1'b0, 1'b0); tick();
        set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("mid_pre_occupancy", 32'(occupancy), SKID ? 32'd2 : 32'd1);
        tick();
        set_in(1'b1, 1'b1, 8'h43, 1'b0, 1'b0); tick();
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_occupancy", 32'(occupancy), 32'd0);
        chk("mid_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("mid_in_ready", 32'(in_ready), 32'd1);
        chk("mid_out_data", 32'(out_data), 32'd0);
        tick();

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
